// File: rtl/main_fsm.sv
// Moore control FSM for the multi-cycle RISC-V datapath (fetch/decode/execute/memory/writeback).
// Outputs are registered from the next-state decode, so they present the current state's values.
module main_fsm #(
   parameter int unsigned MEM_LATENCY = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       illegal
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);
   // FETCH is a final-wait cycle straight out of reset only for single-cycle memory
   localparam logic FETCH_FIN_RST = (LAT == '0);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_RTYP = 7'b0110011;
   localparam logic [6:0] OP_ITYP = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             illegal_n;
   logic             fin_n;

   logic       pc_update_n, branch_n, reg_write_n, mem_write_n, ir_write_n, adr_src_n;
   logic [1:0] result_src_n, alu_src_a_n, alu_src_b_n, alu_op_n;

   // State, wait counter and outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FETCH;
         cnt       <= '0;
         illegal   <= 1'b0;
         PCUpdate  <= FETCH_FIN_RST;
         Branch    <= 1'b0;
         RegWrite  <= 1'b0;
         MemWrite  <= 1'b0;
         IRWrite   <= FETCH_FIN_RST;
         AdrSrc    <= 1'b0;
         ResultSrc <= 2'b10;
         ALUSrcA   <= 2'b00;
         ALUSrcB   <= 2'b10;
         ALUOp     <= 2'b00;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         illegal   <= illegal_n;
         PCUpdate  <= pc_update_n;
         Branch    <= branch_n;
         RegWrite  <= reg_write_n;
         MemWrite  <= mem_write_n;
         IRWrite   <= ir_write_n;
         AdrSrc    <= adr_src_n;
         ResultSrc <= result_src_n;
         ALUSrcA   <= alu_src_a_n;
         ALUSrcB   <= alu_src_b_n;
         ALUOp     <= alu_op_n;
      end
   end

   // Next state, counter, and output decode of the next state
   always_comb begin
      state_n      = state;
      cnt_n        = '0;
      illegal_n    = illegal;
      pc_update_n  = 1'b0;
      branch_n     = 1'b0;
      reg_write_n  = 1'b0;
      mem_write_n  = 1'b0;
      ir_write_n   = 1'b0;
      adr_src_n    = 1'b0;
      result_src_n = 2'b00;
      alu_src_a_n  = 2'b00;
      alu_src_b_n  = 2'b00;
      alu_op_n     = 2'b00;

      // Counter runs only while a wait state is held; any exit or entry leaves it at zero
      case (state)
         FETCH:    if (cnt == LAT) state_n = DECODE;  else cnt_n = cnt + CNT_W'(1);
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_n = MEMADR;
               OP_RTYP:      state_n = EXECUTER;
               OP_ITYP:      state_n = EXECUTEI;
               OP_BEQ:       state_n = BEQ;
               OP_JAL:       state_n = JAL;
               default: begin
                  state_n   = FETCH;
                  illegal_n = 1'b1;
               end
            endcase
         end
         MEMADR:   state_n = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  if (cnt == LAT) state_n = MEMWB; else cnt_n = cnt + CNT_W'(1);
         MEMWB:    state_n = FETCH;
         MEMWRITE: if (cnt == LAT) state_n = FETCH; else cnt_n = cnt + CNT_W'(1);
         EXECUTER: state_n = ALUWB;
         EXECUTEI: state_n = ALUWB;
         ALUWB:    state_n = FETCH;
         BEQ:      state_n = FETCH;
         JAL:      state_n = ALUWB;
         default:  state_n = FETCH;
      endcase

      fin_n = (cnt_n == LAT);

      case (state_n)
         FETCH: begin
            result_src_n = 2'b10;
            alu_src_b_n  = 2'b10;
            ir_write_n   = fin_n;
            pc_update_n  = fin_n;
         end
         DECODE: begin
            alu_src_a_n = 2'b01;
            alu_src_b_n = 2'b01;
         end
         MEMADR: begin
            alu_src_a_n = 2'b10;
            alu_src_b_n = 2'b01;
         end
         MEMREAD:  adr_src_n = 1'b1;
         MEMWB: begin
            result_src_n = 2'b01;
            reg_write_n  = 1'b1;
         end
         MEMWRITE: begin
            adr_src_n   = 1'b1;
            mem_write_n = fin_n;
         end
         EXECUTER: begin
            alu_src_a_n = 2'b10;
            alu_op_n    = 2'b10;
         end
         EXECUTEI: begin
            alu_src_a_n = 2'b10;
            alu_src_b_n = 2'b01;
            alu_op_n    = 2'b10;
         end
         ALUWB:    reg_write_n = 1'b1;
         BEQ: begin
            alu_src_a_n = 2'b10;
            alu_op_n    = 2'b01;
            branch_n    = 1'b1;
         end
         JAL: begin
            alu_src_a_n = 2'b01;
            alu_src_b_n = 2'b10;
            pc_update_n = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: one instance with single-cycle memory, one with two wait cycles.
module tb_main_fsm;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_RTYP = 7'b0110011;
   localparam logic [6:0] OP_ITYP = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BAD  = 7'b1111111;

   // {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
   localparam logic [13:0] E_FF   = {6'b100010, 2'b10, 2'b00, 2'b10, 2'b00};
   localparam logic [13:0] E_FW   = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00};
   localparam logic [13:0] E_DEC  = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};
   localparam logic [13:0] E_MA   = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
   localparam logic [13:0] E_MR   = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [13:0] E_MWB  = {6'b001000, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [13:0] E_WRW  = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [13:0] E_WRF  = {6'b000101, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [13:0] E_EXR  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10};
   localparam logic [13:0] E_EXI  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10};
   localparam logic [13:0] E_AWB  = {6'b001000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [13:0] E_BEQ  = {6'b010000, 2'b00, 2'b10, 2'b00, 2'b01};
   localparam logic [13:0] E_JAL  = {6'b100000, 2'b00, 2'b01, 2'b10, 2'b00};

   typedef struct {
      logic [6:0]  op;
      logic [13:0] exp;
      logic        ill;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [6:0] op0 = 7'd0, op2 = 7'd0;

   logic       pcu0, br0, rw0, mw0, irw0, adr0, ill0;
   logic [1:0] rs0, sa0, sb0, aop0;
   logic       pcu2, br2, rw2, mw2, irw2, adr2, ill2;
   logic [1:0] rs2, sa2, sb2, aop2;

   int errors = 0;
   int checks = 0;

   vec_t v0[$];
   vec_t v2[$];

   always #5 clk = ~clk;

   main_fsm #(.MEM_LATENCY(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .op(op0),
      .PCUpdate(pcu0), .Branch(br0), .RegWrite(rw0), .MemWrite(mw0), .IRWrite(irw0),
      .AdrSrc(adr0), .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(aop0),
      .illegal(ill0)
   );

   main_fsm #(.MEM_LATENCY(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .op(op2),
      .PCUpdate(pcu2), .Branch(br2), .RegWrite(rw2), .MemWrite(mw2), .IRWrite(irw2),
      .AdrSrc(adr2), .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ALUOp(aop2),
      .illegal(ill2)
   );

   wire [14:0] act0 = {pcu0, br0, rw0, mw0, irw0, adr0, rs0, sa0, sb0, aop0, ill0};
   wire [14:0] act2 = {pcu2, br2, rw2, mw2, irw2, adr2, rs2, sa2, sb2, aop2, ill2};

   task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b", nm, act, exp);
      end
   endtask

   // Called at a falling edge: drive op, compare this cycle's outputs, advance one cycle
   task automatic apply(input int sel, input string nm, input vec_t v);
      if (sel == 0) op0 = v.op; else op2 = v.op;
      #1;
      if (sel == 0) chk(nm, act0, {v.exp, v.ill});
      else          chk(nm, act2, {v.exp, v.ill});
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      op0 = 7'd0;
      op2 = 7'd0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      // Single-cycle memory: R, lw, I, beq, jal, sw, lw/sw redirect at MEMADR, illegal
      v0.push_back('{OP_BAD,  E_FF,  1'b0});
      v0.push_back('{OP_RTYP, E_DEC, 1'b0});
      v0.push_back('{OP_BAD,  E_EXR, 1'b0});
      v0.push_back('{OP_BAD,  E_AWB, 1'b0});
      v0.push_back('{OP_BAD,  E_FF,  1'b0});
      v0.push_back('{OP_LW,   E_DEC, 1'b0});
      v0.push_back('{OP_LW,   E_MA,  1'b0});
      v0.push_back('{OP_BAD,  E_MR,  1'b0});
      v0.push_back('{OP_BAD,  E_MWB, 1'b0});
      v0.push_back('{OP_ITYP, E_FF,  1'b0});
      v0.push_back('{OP_ITYP, E_DEC, 1'b0});
      v0.push_back('{OP_ITYP, E_EXI, 1'b0});
      v0.push_back('{OP_ITYP, E_AWB, 1'b0});
      v0.push_back('{OP_BEQ,  E_FF,  1'b0});
      v0.push_back('{OP_BEQ,  E_DEC, 1'b0});
      v0.push_back('{OP_BEQ,  E_BEQ, 1'b0});
      v0.push_back('{OP_JAL,  E_FF,  1'b0});
      v0.push_back('{OP_JAL,  E_DEC, 1'b0});
      v0.push_back('{OP_JAL,  E_JAL, 1'b0});
      v0.push_back('{OP_JAL,  E_AWB, 1'b0});
      v0.push_back('{OP_SW,   E_FF,  1'b0});
      v0.push_back('{OP_SW,   E_DEC, 1'b0});
      v0.push_back('{OP_SW,   E_MA,  1'b0});
      v0.push_back('{OP_SW,   E_WRF, 1'b0});
      v0.push_back('{OP_LW,   E_FF,  1'b0});
      v0.push_back('{OP_LW,   E_DEC, 1'b0});
      v0.push_back('{OP_SW,   E_MA,  1'b0});
      v0.push_back('{OP_LW,   E_WRF, 1'b0});
      v0.push_back('{OP_BAD,  E_FF,  1'b0});
      v0.push_back('{OP_BAD,  E_DEC, 1'b0});
      v0.push_back('{OP_RTYP, E_FF,  1'b1});
      v0.push_back('{OP_RTYP, E_DEC, 1'b1});
      v0.push_back('{OP_RTYP, E_EXR, 1'b1});
      v0.push_back('{OP_RTYP, E_AWB, 1'b1});
      v0.push_back('{OP_RTYP, E_FF,  1'b1});

      // Two wait cycles: sw, lw, illegal, then sw interrupted by reset in its final MEMWRITE cycle
      v2.push_back('{OP_SW,   E_FW,  1'b0});
      v2.push_back('{OP_SW,   E_FW,  1'b0});
      v2.push_back('{OP_SW,   E_FF,  1'b0});
      v2.push_back('{OP_SW,   E_DEC, 1'b0});
      v2.push_back('{OP_SW,   E_MA,  1'b0});
      v2.push_back('{OP_BAD,  E_WRW, 1'b0});
      v2.push_back('{OP_BAD,  E_WRW, 1'b0});
      v2.push_back('{OP_BAD,  E_WRF, 1'b0});
      v2.push_back('{OP_LW,   E_FW,  1'b0});
      v2.push_back('{OP_LW,   E_FW,  1'b0});
      v2.push_back('{OP_LW,   E_FF,  1'b0});
      v2.push_back('{OP_LW,   E_DEC, 1'b0});
      v2.push_back('{OP_LW,   E_MA,  1'b0});
      v2.push_back('{OP_BAD,  E_MR,  1'b0});
      v2.push_back('{OP_BAD,  E_MR,  1'b0});
      v2.push_back('{OP_BAD,  E_MR,  1'b0});
      v2.push_back('{OP_BAD,  E_MWB, 1'b0});
      v2.push_back('{OP_BAD,  E_FW,  1'b0});
      v2.push_back('{OP_BAD,  E_FW,  1'b0});
      v2.push_back('{OP_BAD,  E_FF,  1'b0});
      v2.push_back('{OP_BAD,  E_DEC, 1'b0});
      v2.push_back('{OP_SW,   E_FW,  1'b1});
      v2.push_back('{OP_SW,   E_FW,  1'b1});
      v2.push_back('{OP_SW,   E_FF,  1'b1});
      v2.push_back('{OP_SW,   E_DEC, 1'b1});
      v2.push_back('{OP_SW,   E_MA,  1'b1});
      v2.push_back('{OP_SW,   E_WRW, 1'b1});
      v2.push_back('{OP_SW,   E_WRW, 1'b1});

      do_reset();
      foreach (v0[i]) apply(0, $sformatf("lat0 vec %0d", i), v0[i]);

      do_reset();
      foreach (v2[i]) apply(2, $sformatf("lat2 vec %0d", i), v2[i]);

      // Final MEMWRITE cycle: MemWrite high, then async reset must drop it at once
      #1;
      chk("lat2 memwrite final", act2, {E_WRF, 1'b1});
      #2;
      reset_n = 1'b0;
      #1;
      chk("lat2 reset in memwrite", act2, {E_FW, 1'b0});
      chk("lat0 reset mid-run", act0, {E_FF, 1'b0});
      @(negedge clk);
      #1;
      chk("lat2 held in reset", act2, {E_FW, 1'b0});
      @(negedge clk);
      reset_n = 1'b1;
      apply(2, "lat2 post-reset fetch 1", '{OP_RTYP, E_FW,  1'b0});
      apply(2, "lat2 post-reset fetch 2", '{OP_RTYP, E_FW,  1'b0});
      apply(2, "lat2 post-reset fetch 3", '{OP_RTYP, E_FF,  1'b0});
      apply(2, "lat2 post-reset decode",  '{OP_RTYP, E_DEC, 1'b0});
      apply(2, "lat2 post-reset exec",    '{OP_RTYP, E_EXR, 1'b0});
      apply(2, "lat2 post-reset aluwb",   '{OP_RTYP, E_AWB, 1'b0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
